bus_arbiter_rr: RTL and testbench

BUS_ARBITER_RR -- requirements
Module: bus_arbiter_rr

---
 rtl/bus_arbiter_rr.sv | 192 +++++++++++++++++++
 tb/tb_bus_arbiter_rr.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bus_arbiter_rr.sv
// Round-robin arbiter that funnels NUM_CH client channels onto one line-based
// memory bus. A grant moves one full line (BEATS beats): writes are gathered
// from the client into the line buffer and then streamed to the bus; reads are
// gathered from the bus and then streamed back to the client.
module bus_arbiter_rr #(
  parameter int NUM_CH         = 2,
  parameter int BUS_DATA_WIDTH = 64,
  parameter int BUS_TAG_WIDTH  = 13,
  parameter int BEATS          = 8,
  localparam int PW            = $clog2(BEATS),
  localparam int GW            = $clog2(NUM_CH)
) (
  input  logic                              clk,
  input  logic                              reset,
  output logic                              ready,
  // client side
  input  logic [NUM_CH-1:0]                 reqcyc,
  output logic [NUM_CH-1:0]                 reqack,
  input  logic [NUM_CH*BUS_DATA_WIDTH-1:0]  req,
  input  logic [NUM_CH*BUS_TAG_WIDTH-1:0]   reqtag,
  output logic [NUM_CH-1:0]                 respcyc,
  input  logic [NUM_CH-1:0]                 respack,
  output logic [BUS_DATA_WIDTH-1:0]         resp,
  output logic [BUS_TAG_WIDTH-1:0]          resptag,
  output logic [PW-1:0]                     ptr,
  // memory side
  output logic                              bus_reqcyc,
  input  logic                              bus_reqack,
  output logic [BUS_DATA_WIDTH-1:0]         bus_req,
  output logic [BUS_TAG_WIDTH-1:0]          bus_reqtag,
  input  logic                              bus_respcyc,
  output logic                              bus_respack,
  input  logic [BUS_DATA_WIDTH-1:0]         bus_resp,
  input  logic [BUS_TAG_WIDTH-1:0]          bus_resptag
);

  localparam int W  = BUS_DATA_WIDTH;
  localparam int TW = BUS_TAG_WIDTH;

  typedef enum logic [2:0] {
    IDLE, ACKREQ, WRDATA, ACKDATA, BUSREQ, BUSWR, BUSRD, RESP
  } state_t;

  state_t               state_q, state_d;
  logic [GW-1:0]        gnt_q, gnt_d;
  logic [GW-1:0]        last_q, last_d;
  logic [PW-1:0]        ptr_q, ptr_d;
  logic [W-1:0]         addr_q, addr_d;
  logic [TW-1:0]        tag_q, tag_d;
  logic [BEATS*W-1:0]   line_q, line_d;

  logic                 rr_found;
  logic [GW-1:0]        rr_idx;
  logic                 is_write;
  logic                 last_beat;
  logic [NUM_CH-1:0]    gnt_oh;

  // The bus response tag carries nothing the arbiter needs.
  logic unused_bus_resptag;
  assign unused_bus_resptag = ^bus_resptag;

  // Channel index base+k, wrapped into 0..NUM_CH-1.
  function automatic logic [GW-1:0] wrap_idx(input logic [GW-1:0] base, input int k);
    int c;
    c = int'(base) + k;
    if (c >= NUM_CH) c = c - NUM_CH;
    return GW'(c);
  endfunction

  assign is_write  = tag_q[TW-1];
  assign last_beat = (ptr_q == PW'(BEATS-1));
  assign gnt_oh    = {{(NUM_CH-1){1'b0}}, 1'b1} << gnt_q;

  // Round-robin search: first requester after the last granted channel.
  always_comb begin
    rr_found = 1'b0;
    rr_idx   = '0;
    for (int k = 1; k <= NUM_CH; k++) begin
      if (!rr_found && reqcyc[wrap_idx(last_q, k)]) begin
        rr_found = 1'b1;
        rr_idx   = wrap_idx(last_q, k);
      end
    end
  end

  // State and datapath registers; reset abandons any transaction in flight.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      gnt_q   <= '0;
      last_q  <= GW'(NUM_CH-1);
      ptr_q   <= '0;
      addr_q  <= '0;
      tag_q   <= '0;
      line_q  <= '0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      last_q  <= last_d;
      ptr_q   <= ptr_d;
      addr_q  <= addr_d;
      tag_q   <= tag_d;
      line_q  <= line_d;
    end
  end

  // Next-state and datapath update for the transaction sequencer.
  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    last_d  = last_q;
    ptr_d   = ptr_q;
    addr_d  = addr_q;
    tag_d   = tag_q;
    line_d  = line_q;
    case (state_q)
      IDLE: begin
        if (rr_found) begin
          gnt_d   = rr_idx;
          last_d  = rr_idx;
          addr_d  = req[rr_idx*W +: W];
          tag_d   = reqtag[rr_idx*TW +: TW];
          ptr_d   = '0;
          state_d = ACKREQ;
        end
      end
      ACKREQ: state_d = is_write ? WRDATA : BUSREQ;
      WRDATA: begin
        if (reqcyc[gnt_q]) begin
          line_d[ptr_q*W +: W] = req[gnt_q*W +: W];
          state_d = ACKDATA;
        end
      end
      ACKDATA: begin
        if (last_beat) begin
          ptr_d   = '0;
          state_d = BUSREQ;
        end else begin
          ptr_d   = ptr_q + 1'b1;
          state_d = WRDATA;
        end
      end
      BUSREQ: if (bus_reqack) state_d = is_write ? BUSWR : BUSRD;
      BUSWR: begin
        if (bus_reqack) begin
          ptr_d = ptr_q + 1'b1;
          if (last_beat) begin
            ptr_d   = '0;
            state_d = IDLE;
          end
        end
      end
      BUSRD: begin
        if (bus_respcyc) begin
          line_d[ptr_q*W +: W] = bus_resp;
          ptr_d = ptr_q + 1'b1;
          if (last_beat) begin
            ptr_d   = '0;
            state_d = RESP;
          end
        end
      end
      RESP: begin
        if (respack[gnt_q]) begin
          ptr_d = ptr_q + 1'b1;
          if (last_beat) begin
            ptr_d   = '0;
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Outputs decoded from registered state; only bus_respack follows an input,
  // so stray bus responses outside BUSRD are still drained.
  always_comb begin
    ready       = (state_q == IDLE);
    reqack      = (state_q == ACKREQ || state_q == ACKDATA) ? gnt_oh : '0;
    respcyc     = (state_q == RESP) ? gnt_oh : '0;
    resp        = (state_q == RESP) ? line_q[ptr_q*W +: W] : '0;
    resptag     = (state_q == RESP) ? tag_q : '0;
    ptr         = ptr_q;
    bus_reqcyc  = (state_q == BUSREQ || state_q == BUSWR);
    bus_req     = (state_q == BUSREQ) ? addr_q :
                  (state_q == BUSWR)  ? line_q[ptr_q*W +: W] : '0;
    bus_reqtag  = bus_reqcyc ? tag_q : '0;
    bus_respack = bus_respcyc & reset;
  end

endmodule

// File: tb/tb_bus_arbiter_rr.sv
// Directed bench for bus_arbiter_rr: a 2-channel instance driven cycle by cycle
// and a 4-channel instance left saturated to observe grant rotation.
module tb_bus_arbiter_rr;
  localparam int W = 64, TW = 13;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // 2-channel instance
  logic          reset;
  logic          ready;
  logic [1:0]    reqcyc, reqack, respcyc, respack;
  logic [127:0]  req;
  logic [25:0]   reqtag;
  logic [63:0]   resp;
  logic [12:0]   resptag;
  logic [2:0]    ptr;
  logic          bus_reqcyc, bus_reqack, bus_respcyc, bus_respack;
  logic [63:0]   bus_req, bus_resp;
  logic [12:0]   bus_reqtag, bus_resptag;

  bus_arbiter_rr dut (
    .clk(clk), .reset(reset), .ready(ready),
    .reqcyc(reqcyc), .reqack(reqack), .req(req), .reqtag(reqtag),
    .respcyc(respcyc), .respack(respack), .resp(resp), .resptag(resptag), .ptr(ptr),
    .bus_reqcyc(bus_reqcyc), .bus_reqack(bus_reqack), .bus_req(bus_req),
    .bus_reqtag(bus_reqtag), .bus_respcyc(bus_respcyc), .bus_respack(bus_respack),
    .bus_resp(bus_resp), .bus_resptag(bus_resptag)
  );

  // 4-channel instance with every handshake input tied active
  logic          reset4, ready4;
  logic [3:0]    reqcyc4, reqack4, respcyc4, respack4;
  logic [255:0]  req4;
  logic [51:0]   reqtag4;
  logic [63:0]   resp4, bus_req4, bus_resp4;
  logic [12:0]   resptag4, bus_reqtag4, bus_resptag4;
  logic [2:0]    ptr4;
  logic          bus_reqcyc4, bus_reqack4, bus_respcyc4, bus_respack4;

  bus_arbiter_rr #(.NUM_CH(4)) dut4 (
    .clk(clk), .reset(reset4), .ready(ready4),
    .reqcyc(reqcyc4), .reqack(reqack4), .req(req4), .reqtag(reqtag4),
    .respcyc(respcyc4), .respack(respack4), .resp(resp4), .resptag(resptag4), .ptr(ptr4),
    .bus_reqcyc(bus_reqcyc4), .bus_reqack(bus_reqack4), .bus_req(bus_req4),
    .bus_reqtag(bus_reqtag4), .bus_respcyc(bus_respcyc4), .bus_respack(bus_respack4),
    .bus_resp(bus_resp4), .bus_resptag(bus_resptag4)
  );

  int tests = 0;
  int fails = 0;

  task automatic step();
    @(negedge clk);
  endtask

  // Zero-wait memory for a read: entered at the ACKREQ negedge, leaves at the
  // first RESP negedge.
  task automatic drive_bus_read(input logic [63:0] base);
    step();
    bus_reqack = 1'b1;
    step();
    bus_reqack = 1'b0;
    for (int k = 0; k < 8; k++) begin
      bus_respcyc = 1'b1;
      bus_resp    = base + 64'(k);
      step();
    end
    bus_respcyc = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b0; reset4 = 1'b0;
    reqcyc = 2'b11; respack = 2'b11; req = '0; reqtag = '0;
    bus_reqack = 1'b1; bus_respcyc = 1'b1; bus_resp = 64'hdead; bus_resptag = '0;
    reqcyc4 = 4'hF; respack4 = 4'hF; req4 = '0; reqtag4 = '0;
    bus_reqack4 = 1'b1; bus_respcyc4 = 1'b1; bus_resp4 = '0; bus_resptag4 = '0;
    repeat (3) step();
    tests++; if (ready !== 1'b1) begin fails++; $display("FAIL rst_ready: got %b want 1", ready); end
    tests++; if (reqack !== 2'b00) begin fails++; $display("FAIL rst_reqack: got %b want 00", reqack); end
    tests++; if (respcyc !== 2'b00) begin fails++; $display("FAIL rst_respcyc: got %b want 00", respcyc); end
    tests++; if (bus_reqcyc !== 1'b0) begin fails++; $display("FAIL rst_bus_reqcyc: got %b want 0", bus_reqcyc); end
    tests++; if (bus_respack !== 1'b0) begin fails++; $display("FAIL rst_bus_respack: got %b want 0", bus_respack); end
    tests++;
    if ({resp, resptag, ptr} !== '0) begin
      fails++; $display("FAIL rst_resp: got resp=%h tag=%h ptr=%0d want 0", resp, resptag, ptr);
    end
    tests++;
    if ({bus_req, bus_reqtag} !== '0) begin
      fails++; $display("FAIL rst_bus_req: got %h/%h want 0", bus_req, bus_reqtag);
    end
    reqcyc = 2'b00; respack = 2'b00; bus_reqack = 1'b0; bus_respcyc = 1'b0;
    reset = 1'b1;
    step();
    tests++; if (ready !== 1'b1) begin fails++; $display("FAIL post_rst_idle: got %b want 1", ready); end
  endtask

  task automatic test_read_ch0();
    logic ok;
    req[63:0] = 64'h1000; reqtag[12:0] = 13'h0123; reqcyc = 2'b01;
    step();  // ACKREQ
    tests++; if (reqack !== 2'b01 || ready !== 1'b0) begin
      fails++; $display("FAIL rd_reqack: got ack=%b ready=%b want 01/0", reqack, ready);
    end
    reqcyc = 2'b00;
    step();  // BUSREQ
    tests++; if (bus_reqcyc !== 1'b1 || bus_req !== 64'h1000 || bus_reqtag !== 13'h0123) begin
      fails++; $display("FAIL rd_busreq: got cyc=%b req=%h tag=%h want 1/1000/0123", bus_reqcyc, bus_req, bus_reqtag);
    end
    bus_reqack = 1'b1;
    step();  // BUSRD
    bus_reqack = 1'b0;
    tests++; if (bus_reqcyc !== 1'b0) begin fails++; $display("FAIL rd_busreq_drop: got %b want 0", bus_reqcyc); end
    ok = 1'b1;
    for (int k = 0; k < 8; k++) begin
      bus_respcyc = 1'b1; bus_resp = 64'(k);
      #1;
      if (bus_respack !== 1'b1) ok = 1'b0;
      step();
    end
    bus_respcyc = 1'b0;
    tests++; if (!ok) begin fails++; $display("FAIL rd_bus_respack: got 0 on some beat want 1"); end
    // grant in cycle 0, first respcyc in cycle 3+BEATS = 11
    tests++; if (respcyc !== 2'b01) begin fails++; $display("FAIL rd_latency: got respcyc=%b at cycle 11 want 01", respcyc); end
    respack = 2'b01;
    for (int k = 0; k < 8; k++) begin
      tests++;
      if (respcyc !== 2'b01 || resp !== 64'(k) || ptr !== 3'(k) || resptag !== 13'h0123) begin
        fails++;
        $display("FAIL rd_beat%0d: got cyc=%b resp=%h ptr=%0d tag=%h want 01/%0h/%0d/0123", k, respcyc, resp, ptr, resptag, k, k);
      end
      step();
    end
    respack = 2'b00;
    tests++; if (respcyc !== 2'b00 || ready !== 1'b1) begin
      fails++; $display("FAIL rd_done: got cyc=%b ready=%b want 00/1", respcyc, ready);
    end
  endtask

  task automatic test_write_ch1_stall();
    int  pulses;
    logic stray, stable;
    pulses = 0; stray = 1'b0; stable = 1'b1;
    req[127:64] = 64'h2040; reqtag[25:13] = 13'h1005; reqcyc = 2'b10;
    for (int i = 0; i < 17; i++) begin
      step();
      if (reqack[0] || respcyc !== 2'b00) stray = 1'b1;
      if (reqack[1]) begin
        pulses++;
        req[127:64] = 64'hA0 + 64'(pulses - 1);
      end
    end
    reqcyc = 2'b00;
    step();  // BUSREQ
    tests++; if (pulses != 9) begin fails++; $display("FAIL wr_reqack_pulses: got %0d want 9", pulses); end
    tests++; if (bus_reqcyc !== 1'b1 || bus_req !== 64'h2040 || bus_reqtag !== 13'h1005) begin
      fails++; $display("FAIL wr_busreq: got cyc=%b req=%h tag=%h want 1/2040/1005", bus_reqcyc, bus_req, bus_reqtag);
    end
    for (int s = 0; s < 5; s++) begin
      if (bus_reqcyc !== 1'b1 || bus_req !== 64'h2040) stable = 1'b0;
      step();
    end
    tests++; if (!stable) begin fails++; $display("FAIL wr_stall: got bus_req moving during stall want stable 2040"); end
    bus_reqack = 1'b1;
    step();  // BUSWR beat 0
    for (int k = 0; k < 8; k++) begin
      tests++;
      if (bus_reqcyc !== 1'b1 || bus_req !== 64'hA0 + 64'(k)) begin
        fails++; $display("FAIL wr_beat%0d: got cyc=%b data=%h want 1/%h", k, bus_reqcyc, bus_req, 64'hA0 + 64'(k));
      end
      if (respcyc !== 2'b00) stray = 1'b1;
      step();
    end
    bus_reqack = 1'b0;
    tests++; if (ready !== 1'b1 || bus_reqcyc !== 1'b0) begin
      fails++; $display("FAIL wr_done: got ready=%b bus_reqcyc=%b want 1/0", ready, bus_reqcyc);
    end
    tests++; if (stray) begin fails++; $display("FAIL wr_stray: got reqack[0] or respcyc during write want none"); end
  endtask

  task automatic test_rr_pending();
    logic ok;
    req[63:0] = 64'h3000; reqtag[12:0] = 13'h0011;
    req[127:64] = 64'h3100; reqtag[25:13] = 13'h0022;
    reqcyc = 2'b11;
    step();
    // ch1 was granted last, so ch0 wins
    tests++; if (reqack !== 2'b01) begin fails++; $display("FAIL rr_first: got %b want 01", reqack); end
    reqcyc = 2'b10;
    drive_bus_read(64'h50);
    respack = 2'b10;
    step();
    tests++; if (respcyc !== 2'b01 || ptr !== 3'd0 || resp !== 64'h50) begin
      fails++; $display("FAIL rr_foreign_ack: got cyc=%b ptr=%0d resp=%h want 01/0/50", respcyc, ptr, resp);
    end
    respack = 2'b01; ok = 1'b1;
    for (int k = 0; k < 8; k++) begin
      if (reqack !== 2'b00 || resp !== 64'h50 + 64'(k)) ok = 1'b0;
      step();
    end
    respack = 2'b00;
    tests++; if (!ok) begin fails++; $display("FAIL rr_pending: got reqack or wrong data during ch0 response want none"); end
    step();
    tests++; if (reqack !== 2'b10) begin fails++; $display("FAIL rr_second: got %b want 10", reqack); end
  endtask

  task automatic test_resp_stall_reset();
    logic ok;
    reqcyc = 2'b00;
    drive_bus_read(64'h60);
    respack = 2'b10;
    step(); step();
    respack = 2'b00; ok = 1'b1;
    for (int s = 0; s < 3; s++) begin
      if (respcyc !== 2'b10 || resp !== 64'h62 || ptr !== 3'd2 || resptag !== 13'h0022) ok = 1'b0;
      step();
    end
    tests++; if (!ok) begin fails++; $display("FAIL resp_stall: got resp=%h ptr=%0d want 62/2 held", resp, ptr); end
    respack = 2'b10;
    step(); step();
    respack = 2'b00;
    tests++; if (ptr !== 3'd4 || resp !== 64'h64) begin
      fails++; $display("FAIL resp_beat4: got ptr=%0d resp=%h want 4/64", ptr, resp);
    end
    reset = 1'b0;
    #1;
    tests++; if (respcyc !== 2'b00 || ready !== 1'b1) begin
      fails++; $display("FAIL async_reset: got cyc=%b ready=%b want 00/1", respcyc, ready);
    end
    step();
    reset = 1'b1;
    req[63:0] = 64'h4000; reqtag[12:0] = 13'h0033; reqcyc = 2'b11;
    step();
    tests++; if (reqack !== 2'b01) begin fails++; $display("FAIL post_reset_grant: got %b want 01", reqack); end
    reqcyc = 2'b00;
    drive_bus_read(64'h70);
    respack = 2'b01; ok = 1'b1;
    for (int k = 0; k < 8; k++) begin
      if (respcyc !== 2'b01 || resp !== 64'h70 + 64'(k) || ptr !== 3'(k) || resptag !== 13'h0033) ok = 1'b0;
      step();
    end
    respack = 2'b00;
    tests++; if (!ok) begin fails++; $display("FAIL post_reset_read: got wrong beat data want 70..77"); end
    tests++; if (ready !== 1'b1 || respcyc !== 2'b00) begin
      fails++; $display("FAIL post_reset_done: got ready=%b cyc=%b want 1/00", ready, respcyc);
    end
  endtask

  task automatic test_rr4();
    int order[$];
    int n, idx;
    n = 0;
    reset4 = 1'b1;
    while (order.size() < 8 && n < 400) begin
      step();
      n++;
      if (reqack4 !== 4'h0) begin
        idx = 0;
        for (int j = 0; j < 4; j++) if (reqack4[j]) idx = j;
        order.push_back(idx);
      end
    end
    for (int i = 0; i < 8; i++) begin
      tests++;
      if (i >= order.size()) begin
        fails++; $display("FAIL rr4_grant%0d: got timeout want %0d", i, i % 4);
      end else if (order[i] != i % 4) begin
        fails++; $display("FAIL rr4_grant%0d: got %0d want %0d", i, order[i], i % 4);
      end
    end
  endtask

  initial begin
    test_reset();
    test_read_ch0();
    test_write_ch1_stall();
    test_rr_pending();
    test_resp_stall_reset();
    test_rr4();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
